// File: rtl/bus_pkg.sv
// Shared types for the memory-bus arbiter.
//   arb_state_t : arbiter FSM states.
//   bus_req_t   : one latched slave transaction (address, write data,
//                 byte enables, write flag). The field widths set the
//                 widest bus the arbiter can carry; the arbiter uses the
//                 low ADDR_W / DATA_W bits of each field.
package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = BUS_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } arb_state_t;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_BE_W-1:0]   be;
    logic                  we;
  } bus_req_t;

  // Increment an index, wrapping to 0 at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker.
//   req : request vector, one bit per master.
//   ptr : index that has highest priority; priority falls with
//         increasing index and wraps. Tie to 0 for fixed priority.
//   gnt : one-hot grant (all zero when nothing is requested).
//   idx : index of the granted bit (0 when nothing is requested).
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // NOTE: every variable written here gets a value before any branch;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      // Candidate index = (ptr + off) mod N, kept one bit wider so the
      // wrap compare cannot overflow.
      sum = {1'b0, ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master memory-bus arbiter.
// Merges several request channels (index 0 = data bus, 1 = instruction
// bus, further indices for DMA/debug) onto one external memory port.
//   clk, rst      : core clock; rst is asynchronous and active-low.
//   m_addr/m_load/m_store/m_wdata/m_byte_en : per-master request.
//   m_rdata       : per-master read data, non-zero only in the
//                   completion cycle of the granted master.
//   m_stall_req   : per-master stall, high while a request is pending.
//   s_req/s_we/s_addr/s_wdata/s_be : registered slave request.
//   s_ack/s_rdata : one-cycle slave completion with read data.
// RR_MODE = 0 gives fixed priority (lowest index wins); 1 rotates the
// priority to grant+1 after every finished transaction.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_MODE   = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_MASTERS-1:0][ADDR_W-1:0]    m_addr,
  input  logic [N_MASTERS-1:0]                m_load,
  input  logic [N_MASTERS-1:0]                m_store,
  input  logic [N_MASTERS-1:0][DATA_W-1:0]    m_wdata,
  input  logic [N_MASTERS-1:0][DATA_W/8-1:0]  m_byte_en,
  output logic [N_MASTERS-1:0][DATA_W-1:0]    m_rdata,
  output logic [N_MASTERS-1:0]                m_stall_req,
  output logic                                s_req,
  output logic                                s_we,
  output logic [ADDR_W-1:0]                   s_addr,
  output logic [DATA_W-1:0]                   s_wdata,
  output logic [DATA_W/8-1:0]                 s_be,
  input  logic                                s_ack,
  input  logic [DATA_W-1:0]                   s_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0] requesting;
  logic [N_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     pick_ptr;
  logic [IDX_W-1:0]     next_ptr;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  bus_req_t         req_q,   req_d;

  // A simultaneous load and store is issued as a store.
  assign requesting = m_load | m_store;

  // Fixed priority is the rotating picker with its pointer held at 0.
  assign pick_ptr = (RR_MODE != 0) ? ptr_q : '0;
  assign next_ptr = IDX_W'(wrap_inc(32'(grant_q), N_MASTERS));

  rr_picker #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req (requesting),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    req_d       = req_q;
    m_rdata     = '0;
    m_stall_req = requesting;
    unique case (state_q)
      IDLE: begin
        // s_ack is ignored here: no transaction is outstanding.
        if (|pick_gnt) begin
          grant_d                   = pick_idx;
          req_d                     = '0;
          req_d.addr[ADDR_W-1:0]    = m_addr[pick_idx];
          req_d.wdata[DATA_W-1:0]   = m_wdata[pick_idx];
          req_d.be[BE_W-1:0]        = m_byte_en[pick_idx];
          req_d.we                  = m_store[pick_idx];
          state_d                   = BUSY;
        end
      end
      BUSY: begin
        if (s_ack) begin
          // An ack in the same cycle the master withdraws is dropped
          // without a detour through DRAIN.
          state_d = IDLE;
          ptr_d   = next_ptr;
          if (requesting[grant_q]) begin
            m_rdata[grant_q]     = s_rdata;
            m_stall_req[grant_q] = 1'b0;
          end
        end else if (!requesting[grant_q]) begin
          // Master flushed its request; the slave still has to finish.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (s_ack) begin
          state_d = IDLE;
          ptr_d   = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
    end
  end

  // Slave side comes straight from registers, so it holds steady for the
  // whole BUSY/DRAIN period regardless of what the master does.
  assign s_req   = (state_q != IDLE);
  assign s_we    = req_q.we;
  assign s_addr  = req_q.addr[ADDR_W-1:0];
  assign s_wdata = req_q.wdata[DATA_W-1:0];
  assign s_be    = req_q.be[BE_W-1:0];

endmodule
